// File: rtl/cbus_sram_responder.sv
// cbus_sram_responder: cbus responder serving single-beat and incrementing burst
// reads/writes from a word-addressed on-chip SRAM. Defining CBUS_SRAM_STALL_EN
// adds LFSR-driven ready stalls during the transfer phase.
package cbus_pkg;
    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        logic [3:0]  len;
    } cbus_req_t;
    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;
endpackage

module cbus_sram_responder
    import cbus_pkg::*;
#(
    parameter int         ADDR_WIDTH   = 14,
    parameter int         INIT_LATENCY = 2,
    parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
    input  logic       clk,
    input  logic       resetn,
    input  cbus_req_t  creq,
    output cbus_resp_t cresp
);
    typedef enum logic [1:0] {IDLE, WAIT, XFER} state_t;
    state_t                state, state_n;
    logic [ADDR_WIDTH-1:0] base, base_n, wr_word, rd_word;
    logic [3:0]            len, len_n, beat, beat_n, lat, lat_n;
    logic                  wr, wr_n, ready, we;
    logic [31:0]           rdata;
    logic [31:0]           mem [2**ADDR_WIDTH];
    logic                  unused_req;

    assign unused_req = ^{creq.size, creq.addr[31:ADDR_WIDTH+2], creq.addr[1:0]};

`ifdef CBUS_SRAM_STALL_EN
    logic [7:0] lfsr;

    // Free-running Galois LFSR (x^8+x^6+x^5+x^4+1); its low bit marks stall cycles
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) lfsr <= LFSR_SEED;
        else lfsr <= {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);

    assign ready = (state == XFER) && !lfsr[0];
`else
    logic [7:0] unused_seed;

    assign unused_seed = LFSR_SEED;
    assign ready = state == XFER;
`endif

    assign wr_word = base + ADDR_WIDTH'(beat);
    // Prefetch the word needed next cycle so every beat, including beat 0, is bubble-free
    assign rd_word = (state == IDLE) ? creq.addr[ADDR_WIDTH+1:2] : wr_word + ADDR_WIDTH'(ready);
    assign we = ready && wr && creq.valid;
    assign cresp = '{ready: ready, last: ready && beat == len, data: (ready && !wr) ? rdata : 32'h0};

    // Transaction state register; everything is discarded by reset except the SRAM
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            state <= IDLE;
            base  <= '0;
            len   <= '0;
            wr    <= 1'b0;
            beat  <= '0;
            lat   <= '0;
        end else begin
            state <= state_n;
            base  <= base_n;
            len   <= len_n;
            wr    <= wr_n;
            beat  <= beat_n;
            lat   <= lat_n;
        end

    // Next-state: accept in IDLE, count down latency in WAIT, step beats in XFER; dropped valid aborts
    always_comb begin
        state_n = state;
        base_n  = base;
        len_n   = len;
        wr_n    = wr;
        beat_n  = beat;
        lat_n   = lat;
        case (state)
            IDLE: if (creq.valid) begin
                base_n  = creq.addr[ADDR_WIDTH+1:2];
                len_n   = creq.len;
                wr_n    = creq.is_write;
                beat_n  = '0;
                lat_n   = 4'(INIT_LATENCY);
                state_n = (INIT_LATENCY == 0) ? XFER : WAIT;
            end
            WAIT: begin
                lat_n   = lat - 4'd1;
                state_n = !creq.valid ? IDLE : (lat == 4'd1) ? XFER : WAIT;
            end
            XFER: if (!creq.valid) state_n = IDLE;
            else if (ready) begin
                state_n = (beat == len) ? IDLE : XFER;
                beat_n  = (beat == len) ? beat : beat + 4'd1;
            end
            default: state_n = IDLE;
        endcase
    end

    // SRAM: byte-lane writes on completed write beats, registered read of the next beat's word
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (we && creq.strobe[b]) mem[wr_word][8*b +: 8] <= creq.data[8*b +: 8];
        rdata <= mem[rd_word];
    end
endmodule

// File: tb/tb_cbus_sram_responder.sv
// tb_cbus_sram_responder: scoreboard bench for cbus_sram_responder
module tb_cbus_sram_responder;
    import cbus_pkg::*;
    localparam int LAT = 2;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    cbus_req_t  creq;
    cbus_resp_t cresp;
    int         checks = 0;
    int         errors = 0;
    logic [31:0] model [0:16383];
    logic [31:0] sb [$];
    logic [31:0] wbuf [16];

    cbus_sram_responder #(.ADDR_WIDTH(14), .INIT_LATENCY(LAT), .LFSR_SEED(8'hA5)) dut (
        .clk(clk),
        .resetn(resetn),
        .creq(creq),
        .cresp(cresp)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] word_of(input logic [31:0] a, input int i);
        return 14'((a >> 2) + 32'(i));
    endfunction

    task automatic txn(input logic w, input logic [31:0] addr, input logic [3:0] len,
                       input logic [3:0] strb, input string name);
        int          cycles;
        int          beat;
        int          first;
        logic [13:0] a;
        logic [31:0] exp;
        cbus_resp_t  r;
        for (int i = 0; i <= int'(len); i++) begin
            a = word_of(addr, i);
            if (w) begin
                for (int b = 0; b < 4; b++)
                    if (strb[b]) model[a][8*b +: 8] = wbuf[i][8*b +: 8];
            end else sb.push_back(model[a]);
        end
        creq = '{valid: 1'b1, is_write: w, size: 2'd2, addr: addr, strobe: strb, data: wbuf[0], len: len};
        cycles = 0;
        beat = 0;
        first = 0;
        while (1) begin
            @(negedge clk);
            cycles++;
            r = cresp;
            checks++;
            if (r.ready) begin
                if (first == 0) first = cycles;
                if (r.last !== (beat == int'(len))) begin
                    errors++;
                    $display("FAIL %s last at beat %0d: got %0b want %0b", name, beat, r.last, beat == int'(len));
                end
                exp = 32'h0;
                if (!w) begin
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL %s extra read beat %0d data %h", name, beat, r.data);
                    end else exp = sb.pop_front();
                end
                checks++;
                if (r.data !== exp) begin
                    errors++;
                    $display("FAIL %s data beat %0d: got %h want %h", name, beat, r.data, exp);
                end
            end else if (r.last !== 1'b0 || r.data !== 32'h0) begin
                errors++;
                $display("FAIL %s idle outputs: got last %0b data %h want 0 0", name, r.last, r.data);
            end
            if (cycles > 200) begin
                checks++;
                errors++;
                $display("FAIL %s timeout after %0d beats, want %0d", name, beat, int'(len) + 1);
                creq.valid = 1'b0;
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
            if (r.ready) begin
                if (beat == int'(len)) begin
                    creq.valid = 1'b0;
                    break;
                end
                beat++;
                creq.data = wbuf[beat];
            end
        end
`ifndef CBUS_SRAM_STALL_EN
        // The first sampled cycle precedes the accepting edge, hence LAT+2
        checks++;
        if (first !== LAT + 2) begin
            errors++;
            $display("FAIL %s first beat latency: got %0d want %0d", name, first, LAT + 2);
        end
`endif
    endtask

    task automatic test_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (cresp !== '0) begin
                errors++;
                $display("FAIL reset cycle %0d: got %h want 0", i, cresp);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_burst();
        for (int i = 0; i < 16; i++) wbuf[i] = 32'h1000 + 32'(i);
        txn(1'b1, 32'h0000_0100, 4'd15, 4'hF, "wr16");
        txn(1'b0, 32'h0000_0100, 4'd15, 4'hF, "rd16");
    endtask

    task automatic test_strobe();
        wbuf[0] = 32'hFFFF_FFFF;
        txn(1'b1, 32'h0000_0204, 4'd0, 4'hF, "fill");
        wbuf[0] = 32'hAABB_CCDD;
        txn(1'b1, 32'h0000_0204, 4'd0, 4'b0010, "strb_wr");
        txn(1'b0, 32'h0000_0204, 4'd0, 4'hF, "strb_rd");
        wbuf[0] = 32'h1234_5678;
        txn(1'b1, 32'h0000_0204, 4'd0, 4'h0, "strb0_wr");
        txn(1'b0, 32'h0000_0204, 4'd0, 4'hF, "strb0_rd");
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 16; i++) wbuf[i] = 32'h5000 + 32'(i);
        txn(1'b1, 32'h0000_FFFC, 4'd3, 4'hF, "wrap_wr");
        txn(1'b0, 32'hFFFF_FFFF, 4'd3, 4'hF, "wrap_rd");
        txn(1'b0, 32'h0001_0008, 4'd0, 4'hF, "hi_addr_rd");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) wbuf[i] = 32'hC000 + 32'(i);
        txn(1'b1, 32'h0000_0400, 4'd1, 4'hF, "b2b_wr");
        txn(1'b0, 32'h0000_0400, 4'd1, 4'hF, "b2b_raw");
        txn(1'b0, 32'h0000_0104, 4'd2, 4'hF, "b2b_rd");
    endtask

    task automatic test_mid_reset();
        int          cycles;
        int          beats;
        logic [31:0] exp;
        for (int i = 0; i < 16; i++) sb.push_back(model[word_of(32'h100, i)]);
        creq = '{valid: 1'b1, is_write: 1'b0, size: 2'd2, addr: 32'h100, strobe: 4'hF, data: 32'h0, len: 4'd15};
        cycles = 0;
        beats = 0;
        while (beats < 5 && cycles < 200) begin
            @(negedge clk);
            cycles++;
            if (cresp.ready) begin
                beats++;
                exp = sb.pop_front();
                checks++;
                if (cresp.data !== exp) begin
                    errors++;
                    $display("FAIL mid_reset data beat %0d: got %h want %h", beats, cresp.data, exp);
                end
            end
        end
        checks++;
        if (beats != 5) begin
            errors++;
            $display("FAIL mid_reset timeout: got %0d beats want 5", beats);
        end
        #1 resetn = 1'b0;
        #1;
        checks++;
        if (cresp !== '0) begin
            errors++;
            $display("FAIL mid_reset outputs: got %h want 0", cresp);
        end
        creq.valid = 1'b0;
        sb.delete();
        #7 resetn = 1'b1;
        @(posedge clk);
        #1;
        txn(1'b0, 32'h0000_0100, 4'd3, 4'hF, "post_reset_rd");
    endtask

    task automatic test_stall();
        txn(1'b0, 32'h0000_0120, 4'd7, 4'hF, "rd8");
    endtask

    initial begin
        creq = '0;
        #23 resetn = 1'b1;
        test_reset();
        test_burst();
        test_strobe();
        test_wrap();
        test_back_to_back();
        test_mid_reset();
        test_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
